peripheral_spi_slave: RTL and testbench

J1 SoC memory-mapped SPI slave peripheral: an external SPI master clocks bytes in on MOSI while the block shifts a J1-loaded byte out on MISO. It sits on the J1 I/O bus beside the SPI master peripheral, with the same bus handshake (cs/addr/rd/wr). SPI mode 0, MSB first, 8-bit frames. All SPI pins are asynchronous to clk and are synchronized internally.

---
 rtl/spi_slave_pkg.sv | 20 ++
 rtl/spi_slave.sv | 128 ++++++++++++
 rtl/peripheral_spi_slave.sv | 116 +++++++++++
 tb/tb_peripheral_spi_slave.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// Shared constants and types for the J1 SPI slave peripheral.
package spi_slave_pkg;

    localparam int FRAME_BITS = 8;
    localparam int CNT_W      = $clog2(FRAME_BITS);

    // J1 I/O register offsets (4 LSBs of the address)
    localparam logic [3:0] ADDR_TX    = 4'h0;
    localparam logic [3:0] ADDR_SRST  = 4'h4;
    localparam logic [3:0] ADDR_RX    = 4'h8;
    localparam logic [3:0] ADDR_BUSY  = 4'hA;
    localparam logic [3:0] ADDR_AVAIL = 4'hC;
    localparam logic [3:0] ADDR_OVR   = 4'hE;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } core_state_t;

endpackage

// File: rtl/spi_slave.sv
// SPI mode-0 slave core: pin synchronizers, frame FSM, shift registers and
// bit counter. Produces the received byte, a one-cycle frame_done strobe
// (coincident with the rx_data update), busy and the MISO pin value.
module spi_slave
    import spi_slave_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic [FRAME_BITS-1:0] tx_byte,
    input  logic                  sck,
    input  logic                  ss,
    input  logic                  mosi,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  frame_done,
    output logic                  busy,
    output logic                  miso
);

    // Pin vector layout: {sck, ss, mosi}; idle levels sck=0, ss=1, mosi=0.
    localparam logic [2:0] PIN_IDLE = 3'b010;

    logic [2:0]            pin_in;
    logic [2:0]            meta_reg;
    logic [2:0]            sync_reg;
    logic                  sck_prev_reg;
    logic                  ss_prev_reg;
    logic                  sck_s;
    logic                  ss_s;
    logic                  mosi_s;
    logic                  sck_rise;
    logic                  sck_fall;
    logic                  ss_rise;
    logic                  ss_fall;
    core_state_t           state_reg;
    logic [CNT_W-1:0]      bit_cnt_reg;
    logic [FRAME_BITS-1:0] shift_rx_reg;
    logic [FRAME_BITS-1:0] shift_tx_reg;
    logic [FRAME_BITS-1:0] rx_data_reg;
    logic                  reload_reg;
    logic                  last_bit;

    assign pin_in = {sck, ss, mosi};
    assign sck_s  = sync_reg[2];
    assign ss_s   = sync_reg[1];
    assign mosi_s = sync_reg[0];

    // Two-flop synchronizers plus one history flop for edge detection.
    // Only the hard reset touches them so a soft reset with ss held low
    // cannot fabricate an ss falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_reg     <= PIN_IDLE;
            sync_reg     <= PIN_IDLE;
            sck_prev_reg <= 1'b0;
            ss_prev_reg  <= 1'b1;
        end else begin
            meta_reg     <= pin_in;
            sync_reg     <= meta_reg;
            sck_prev_reg <= sck_s;
            ss_prev_reg  <= ss_s;
        end
    end

    assign sck_rise = sck_s & ~sck_prev_reg;
    assign sck_fall = ~sck_s & sck_prev_reg;
    assign ss_rise  = ss_s & ~ss_prev_reg;
    assign ss_fall  = ~ss_s & ss_prev_reg;
    assign last_bit = (bit_cnt_reg == CNT_W'(FRAME_BITS - 1));

    // Frame FSM: loads tx on ss falling, samples MOSI on sck rising,
    // shifts MISO on sck falling, reloads tx for back-to-back frames.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_reg    <= IDLE;
            bit_cnt_reg  <= '0;
            shift_rx_reg <= '0;
            shift_tx_reg <= '0;
            rx_data_reg  <= '0;
            reload_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (ss_fall) begin
                        state_reg    <= ACTIVE;
                        shift_tx_reg <= tx_byte;
                        bit_cnt_reg  <= '0;
                        reload_reg   <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (ss_rise) begin
                        // Abort or normal end: partial bits are simply dropped.
                        state_reg   <= IDLE;
                        bit_cnt_reg <= '0;
                        reload_reg  <= 1'b0;
                    end else begin
                        if (sck_rise) begin
                            shift_rx_reg <= {shift_rx_reg[FRAME_BITS-2:0], mosi_s};
                            if (last_bit) begin
                                rx_data_reg <= {shift_rx_reg[FRAME_BITS-2:0], mosi_s};
                                bit_cnt_reg <= '0;
                                reload_reg  <= 1'b1;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            end
                        end
                        if (sck_fall) begin
                            if (reload_reg) begin
                                shift_tx_reg <= tx_byte;
                                reload_reg   <= 1'b0;
                            end else begin
                                shift_tx_reg <= {shift_tx_reg[FRAME_BITS-2:0], 1'b0};
                            end
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign frame_done = (state_reg == ACTIVE) && !ss_rise && sck_rise && last_bit;
    assign rx_data    = rx_data_reg;
    assign busy       = ~ss_s;
    assign miso       = ss_s ? 1'b1 : shift_tx_reg[FRAME_BITS-1];

endmodule

// File: rtl/peripheral_spi_slave.sv
// J1 memory-mapped SPI slave peripheral: bus decoder, tx buffer, status
// flags and registered read port around the spi_slave core.
// Optional feature macro: SPI_SLAVE_OVR_EN (sticky overrun flag at 0xE).
module peripheral_spi_slave
    import spi_slave_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] d_in,
    input  logic        cs,
    input  logic [3:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] d_out,
    input  logic        sck,
    input  logic        ss,
    input  logic        mosi,
    output logic        miso
);

    logic                  wr_en;
    logic                  rd_en;
    logic                  soft_rst;
    logic [FRAME_BITS-1:0] tx_buf_reg;
    logic [FRAME_BITS-1:0] rx_data;
    logic                  frame_done;
    logic                  busy;
    logic                  avail_reg;
    logic                  ovr_flag;
    logic [15:0]           rd_data_next;
    logic                  unused_d_in_hi;

    assign wr_en    = cs & wr;
    assign rd_en    = cs & rd;
    assign soft_rst = wr_en && (addr == ADDR_SRST);

    // Only the low byte of write data is meaningful.
    assign unused_d_in_hi = &{1'b0, d_in[15:8]};

    spi_slave u_core (
        .clk        (clk),
        .rst        (rst),
        .clear      (soft_rst),
        .tx_byte    (tx_buf_reg),
        .sck        (sck),
        .ss         (ss),
        .mosi       (mosi),
        .rx_data    (rx_data),
        .frame_done (frame_done),
        .busy       (busy),
        .miso       (miso)
    );

    // Transmit byte; it is not consumed, so it repeats until rewritten.
    always_ff @(posedge clk) begin
        if (rst || soft_rst) begin
            tx_buf_reg <= '0;
        end else if (wr_en && (addr == ADDR_TX)) begin
            tx_buf_reg <= d_in[FRAME_BITS-1:0];
        end
    end

    // Data-available flag: frame completion beats a same-cycle rx read.
    always_ff @(posedge clk) begin
        if (rst || soft_rst) begin
            avail_reg <= 1'b0;
        end else if (frame_done) begin
            avail_reg <= 1'b1;
        end else if (rd_en && (addr == ADDR_RX)) begin
            avail_reg <= 1'b0;
        end
    end

`ifdef SPI_SLAVE_OVR_EN
    logic ovr_reg;

    // Sticky overrun: a frame landed while the previous byte was unread.
    always_ff @(posedge clk) begin
        if (rst || soft_rst) begin
            ovr_reg <= 1'b0;
        end else if (frame_done && avail_reg) begin
            ovr_reg <= 1'b1;
        end else if (rd_en && (addr == ADDR_OVR)) begin
            ovr_reg <= 1'b0;
        end
    end

    assign ovr_flag = ovr_reg;
`else
    assign ovr_flag = 1'b0;
`endif

    // Read data selection for the addressed register.
    always_comb begin
        rd_data_next = 16'h0000;
        case (addr)
            ADDR_RX:    rd_data_next = {8'h00, rx_data};
            ADDR_BUSY:  rd_data_next = {15'h0000, busy};
            ADDR_AVAIL: rd_data_next = {15'h0000, avail_reg};
            ADDR_OVR:   rd_data_next = {15'h0000, ovr_flag};
            default:    rd_data_next = 16'h0000;
        endcase
    end

    // Registered read port: data for one cycle after a read, else zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_out <= 16'h0000;
        end else if (rd_en) begin
            d_out <= rd_data_next;
        end else begin
            d_out <= 16'h0000;
        end
    end

endmodule

// File: tb/tb_peripheral_spi_slave.sv
// Self-checking bench for peripheral_spi_slave: bit-banged SPI master and a
// register-level model of rx byte, avail/ovr flags and tx buffer.
module tb_peripheral_spi_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] d_in;
    logic        cs;
    logic [3:0]  addr;
    logic        rd;
    logic        wr;
    logic [15:0] d_out;
    logic        sck;
    logic        ss;
    logic        mosi;
    logic        miso;

    int tests_run    = 0;
    int tests_failed = 0;

`ifdef SPI_SLAVE_OVR_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    // Reference model state
    logic [7:0] txbuf_m;
    logic [7:0] rx_m;
    bit         avail_m;
    bit         ovr_m;

    always #5 clk = ~clk;

    peripheral_spi_slave dut (
        .clk   (clk),
        .rst   (rst),
        .d_in  (d_in),
        .cs    (cs),
        .addr  (addr),
        .rd    (rd),
        .wr    (wr),
        .d_out (d_out),
        .sck   (sck),
        .ss    (ss),
        .mosi  (mosi),
        .miso  (miso)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
        end
        $display("[TB] %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // A frame finished: a pending unread byte means overrun.
    task automatic model_frame(input logic [7:0] b);
        if (avail_m) ovr_m = 1'b1;
        avail_m = 1'b1;
        rx_m    = b;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0; d_in = 16'h0000;
        if (a == 4'h0) txbuf_m = d[7:0];
        if (a == 4'h4) begin
            txbuf_m = 8'h00; rx_m = 8'h00; avail_m = 1'b0; ovr_m = 1'b0;
        end
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [15:0] d);
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; addr = a;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
        d = d_out;
    endtask

    // Read a register and compare with what the model says it must hold.
    task automatic rd_check(input logic [3:0] a, input string tag);
        logic [15:0] got;
        logic [15:0] exp;
        case (a)
            4'h8:    exp = {8'h00, rx_m};
            4'hA:    exp = {15'h0000, ~ss};
            4'hC:    exp = {15'h0000, avail_m};
            4'hE:    exp = {15'h0000, OVR_EN & ovr_m};
            default: exp = 16'h0000;
        endcase
        bus_read(a, got);
        check(tag, got, exp);
        if (a == 4'h8) avail_m = 1'b0;
        if (a == 4'hE) ovr_m = 1'b0;
    endtask

    // Master side of n bits, MSB first, mode 0; MISO captured at sck rise.
    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < n; i++) begin
            mosi = tx[7-i];
            tick(4);
            rx[7-i] = miso;
            sck = 1'b1;
            tick(4);
            sck = 1'b0;
        end
        tick(4);
    endtask

    task automatic ss_assert();
        ss = 1'b0;
        tick(8);
    endtask

    task automatic ss_release();
        tick(4);
        ss = 1'b1;
        tick(8);
    endtask

    initial begin
        logic [7:0]  r;
        logic [7:0]  b;
        logic [7:0]  b2;
        logic [15:0] dv;
        int          nf;

        rst = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = 4'h0; d_in = 16'h0000;
        sck = 1'b0; ss = 1'b1; mosi = 1'b0;
        txbuf_m = 8'h00; rx_m = 8'h00; avail_m = 1'b0; ovr_m = 1'b0;
        tick(5);
        rst = 1'b0;
        tick(1);

        // Reset state
        check("rst_dout", d_out, 16'h0000);
        check("rst_miso", {15'h0000, miso}, 16'h0001);
        rd_check(4'hA, "rst_busy");
        rd_check(4'hC, "rst_avail");
        rd_check(4'hE, "rst_ovr");

        // Single frame
        bus_write(4'h0, 16'h00A5);
        ss_assert();
        rd_check(4'hA, "s1_busy");
        spi_bits(8'h3C, 8, r);
        check("s1_miso", {8'h00, r}, {8'h00, txbuf_m});
        model_frame(8'h3C);
        ss_release();
        check("s1_miso_idle", {15'h0000, miso}, 16'h0001);
        rd_check(4'hC, "s1_avail");
        rd_check(4'h8, "s1_rx");
        tick(1);
        check("s1_dout_hold0", d_out, 16'h0000);
        rd_check(4'hC, "s1_avail_clr");
        rd_check(4'h3, "s1_unmapped");

        // Back-to-back frames under one ss, no read between
        bus_write(4'h0, 16'h0081);
        ss_assert();
        spi_bits(8'h12, 8, r);
        check("b2b_miso0", {8'h00, r}, {8'h00, txbuf_m});
        model_frame(8'h12);
        spi_bits(8'h34, 8, r);
        check("b2b_miso1", {8'h00, r}, {8'h00, txbuf_m});
        model_frame(8'h34);
        ss_release();
        rd_check(4'hE, "b2b_ovr");
        rd_check(4'hE, "b2b_ovr_clr");
        rd_check(4'h8, "b2b_rx");

        // Abort after 5 bits, then a clean frame
        ss_assert();
        spi_bits(8'($urandom), 5, r);
        ss_release();
        rd_check(4'hC, "abort_avail");
        rd_check(4'h8, "abort_rx");
        ss_assert();
        spi_bits(8'hF0, 8, r);
        check("abort_next_miso", {8'h00, r}, {8'h00, txbuf_m});
        model_frame(8'hF0);
        ss_release();
        rd_check(4'h8, "abort_next_rx");

        // Collision: rx read sampled on the frame completion cycle
        b  = 8'($urandom);
        b2 = 8'($urandom);
        bus_write(4'h0, {8'h00, b2 ^ 8'h5A});
        ss_assert();
        spi_bits(b, 8, r);
        model_frame(b);
        spi_bits(b2, 7, r);
        mosi = b2[0];
        tick(4);
        sck = 1'b1;
        @(negedge clk);
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; addr = 4'h8;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
        check("coll_dout_old", d_out, {8'h00, rx_m});
        model_frame(b2);
        tick(1);
        sck = 1'b0;
        tick(4);
        ss_release();
        rd_check(4'hC, "coll_avail");
        rd_check(4'hE, "coll_ovr");
        rd_check(4'h8, "coll_rx_new");

        // Soft reset mid-frame
        bus_write(4'h0, 16'h00C3);
        ss_assert();
        spi_bits(8'($urandom), 5, r);
        bus_write(4'h4, 16'($urandom));
        rd_check(4'hA, "srst_busy");
        rd_check(4'hC, "srst_avail");
        spi_bits(8'($urandom), 3, r);
        ss_release();
        rd_check(4'hC, "srst_avail_end");
        rd_check(4'h8, "srst_rx");
        rd_check(4'hA, "srst_busy_end");
        b = 8'($urandom);
        ss_assert();
        spi_bits(b, 8, r);
        check("srst_next_miso", {8'h00, r}, {8'h00, txbuf_m});
        model_frame(b);
        ss_release();
        rd_check(4'h8, "srst_next_rx");

        // Randomized frames against the model
        for (int it = 0; it < 8; it++) begin
            if ($urandom_range(0, 1) == 1) bus_write(4'h0, 16'($urandom));
            nf = int'($urandom_range(1, 2));
            ss_assert();
            for (int f = 0; f < nf; f++) begin
                b = 8'($urandom);
                spi_bits(b, 8, r);
                check("rnd_miso", {8'h00, r}, {8'h00, txbuf_m});
                model_frame(b);
            end
            ss_release();
            if ($urandom_range(0, 1) == 1) rd_check(4'hE, "rnd_ovr");
            if ($urandom_range(0, 2) != 0) rd_check(4'h8, "rnd_rx");
            rd_check(4'hC, "rnd_avail");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
